// File: rtl/audio_pkg.sv
// audio_pkg: mode encodings and FSM states shared by the audio echo path.
package audio_pkg;
  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_MUTE  = 2'b01;
  localparam logic [1:0] MODE_DELAY = 2'b10;
  localparam logic [1:0] MODE_ECHO  = 2'b11;
  typedef enum logic [1:0] {IDLE, FETCH, CALC, PUSH} state_e;
endpackage

// File: rtl/audio_delay_ram.sv
// audio_delay_ram: simple dual-port delay line with a 1-cycle registered read.
module audio_delay_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/audio_echo_path.sv
// audio_echo_path: pop a stereo sample, mix it with the delay line per mode, push it back.
module audio_echo_path import audio_pkg::*; #(
  parameter int DATA_W     = 24,
  parameter int DEPTH      = 4096,
  parameter int ECHO_SHIFT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);
  localparam int AW = $clog2(DEPTH);
  state_e            state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] in_l_q, in_r_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       fill_q;
  logic [2*DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] del_l, del_r;
  function automatic logic [DATA_W-1:0] mix(input logic [1:0] m, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] d);
    logic signed [DATA_W:0] s;
    logic [DATA_W-1:0] sat;
    s = $signed({x[DATA_W-1], x}) + ($signed({d[DATA_W-1], d}) >>> ECHO_SHIFT);
    sat = (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
    return m == MODE_PASS ? x : m == MODE_MUTE ? '0 : m == MODE_DELAY ? d : sat;
  endfunction
  assign read  = !reset && state_q == IDLE && read_ready;
  assign write = !reset && state_q == PUSH && write_ready;
  // fill_q saturates at DEPTH, so its top bit alone means the line holds real history
  assign del_l = fill_q[AW] ? rd_data[2*DATA_W-1:DATA_W] : '0;
  assign del_r = fill_q[AW] ? rd_data[DATA_W-1:0] : '0;
  audio_delay_ram #(.W(2*DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (write),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_l_q, in_r_q}),
    .re_i    (state_q == FETCH),
    .raddr_i (wr_ptr_q),
    .rdata_o (rd_data)
  );
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= IDLE;
      writedata_left  <= '0;
      writedata_right <= '0;
      wr_ptr_q        <= '0;
      fill_q          <= '0;
    end else begin
      case (state_q)
        IDLE: if (read_ready) begin
          in_l_q  <= readdata_left;
          in_r_q  <= readdata_right;
          mode_q  <= mode;
          state_q <= FETCH;
        end
        FETCH: state_q <= CALC;
        CALC: begin
          writedata_left  <= mix(mode_q, in_l_q, del_l);
          writedata_right <= mix(mode_q, in_r_q, del_r);
          state_q         <= PUSH;
        end
        PUSH: if (write_ready) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (!fill_q[AW]) fill_q <= fill_q + 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_echo_path.sv
// tb_audio_echo_path: scoreboard bench for the echo path with a history-list reference model.
module tb_audio_echo_path;
  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  mode = 0;
  logic        read_ready = 0, write_ready = 1;
  logic [23:0] ldata = 0, rdata = 0;
  logic        read, write;
  logic [23:0] writedata_left, writedata_right;
  typedef struct {
    logic [23:0] el, er, il, ir;
    int          rcyc;
    bit          lat;
  } exp_t;
  exp_t        sb[$];
  logic [47:0] hist[$];
  int checks = 0, failures = 0, cyc = 0, writes = 0;
  audio_echo_path #(.DATA_W(24), .DEPTH(4), .ECHO_SHIFT(1)) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .mode            (mode),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (ldata),
    .readdata_right  (rdata),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] model(input logic [1:0] m, input logic [23:0] x, input logic [23:0] d);
    int xs, ds, s;
    xs = $signed(x);
    ds = $signed(d);
    s = xs + (ds >>> 1);
    case (m)
      2'b00: return x;
      2'b01: return 24'h0;
      2'b10: return d;
      default: return s > 8388607 ? 24'h7FFFFF : s < -8388608 ? 24'h800000 : 24'(s);
    endcase
  endfunction
  always @(negedge clk) begin
    chk("rw_exclusive", read & write, 0);
    if (write) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wd_left", writedata_left, e.el);
        chk("wd_right", writedata_right, e.er);
        if (e.lat) chk("latency", cyc - e.rcyc, 3);
        hist.push_back({e.il, e.ir});
        writes++;
      end
    end
  end
  task automatic feed(input logic [23:0] l, input logic [23:0] r, input logic [1:0] m);
    bit got = 0;
    read_ready = 1; ldata = l; rdata = r; mode = m;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (read) begin
        exp_t e;
        logic [47:0] d;
        int n = hist.size();
        got = 1;
        d = n >= 4 ? hist[n-4] : 48'h0;
        e.il = l; e.ir = r; e.rcyc = cyc; e.lat = write_ready;
        e.el = model(m, l, d[47:24]);
        e.er = model(m, r, d[23:0]);
        sb.push_back(e);
      end
    end
    if (!got) chk("read_timeout", 0, 1);
    @(posedge clk); #1;
    read_ready = 0; mode = ~m;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [23:0] l, input logic [23:0] r, input logic [1:0] m);
    feed(l, r, m);
    drain();
  endtask
  task automatic do_reset();
    reset = 1; read_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_wdata", {writedata_left, writedata_right}, 0);
    sb.delete();
    hist.delete();
    @(posedge clk); #1;
    reset = 0; read_ready = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [23:0] hold_l, hold_r;
    int bad, w0;
    @(posedge clk); #1;
    do_reset();
    send(24'h000123, 24'hFFFF00, 2'b00);
    do_reset();
    for (int k = 1; k <= 10; k++) send(24'(k), ~24'(k), 2'b10);
    do_reset();
    repeat (4) send(24'h7FFFFF, 24'h7FFFFF, 2'b11);
    send(24'h7FFFFF, 24'h7FFFFF, 2'b11);
    repeat (4) send(24'h800000, 24'h800000, 2'b11);
    send(24'h800000, 24'h800000, 2'b11);
    write_ready = 0;
    feed(24'h0ABCDE, 24'h123456, 2'b00);
    read_ready = 1; ldata = 24'h555555; rdata = 24'hAAAAAA;
    repeat (3) @(negedge clk);
    hold_l = writedata_left; hold_r = writedata_right; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (read || write || writedata_left !== hold_l || writedata_right !== hold_r) bad++;
    end
    chk("bp_stable", bad, 0);
    w0 = writes;
    @(posedge clk); #1;
    write_ready = 1; read_ready = 0;
    drain();
    chk("bp_one_write", writes - w0, 1);
    write_ready = 0;
    feed(24'h111111, 24'h222222, 2'b00);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    w0 = writes;
    do_reset();
    write_ready = 1;
    repeat (5) @(negedge clk);
    chk("rst_abort_no_write", writes - w0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send(24'h300000 + 24'(k), 24'h400000 + 24'(k), 2'b10);
    for (int k = 0; k < 4; k++) send(24'h0F0000 + 24'(k), 24'hF00000 + 24'(k), 2'b01);
    for (int k = 0; k < 4; k++) send(24'h000777, 24'h000888, 2'b10);
    for (int k = 0; k < 20; k++) send(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_echo_path.md
AUDIO_ECHO_PATH -- requirements
Module: audio_echo_path

Interface
REQ-001 SHALL have parameter DATA_W, default 24, signed two's-complement sample width per channel.
REQ-002 SHALL have parameter DEPTH, default 4096, delay-line length in stereo samples; power of two, >= 4.
REQ-003 SHALL have parameter ECHO_SHIFT, default 1, arithmetic right-shift applied to the delayed sample in echo mode.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port mode  in  2  00 pass, 01 mute, 10 delay-only, 11 echo.
REQ-007 SHALL have port read_ready  in  1  codec has a stereo sample available.
REQ-008 SHALL have port write_ready  in  1  codec can accept a stereo sample.
REQ-009 SHALL have ports readdata_left and readdata_right  in  DATA_W  codec input samples.
REQ-010 SHALL have port read  out  1  one-cycle pop strobe to the codec.
REQ-011 SHALL have port write  out  1  one-cycle push strobe to the codec.
REQ-012 SHALL have ports writedata_left and writedata_right  out  DATA_W  processed samples.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, CALC, PUSH.
REQ-014 In IDLE with read_ready=1, SHALL assert read for exactly one cycle, capture both readdata channels and mode in that cycle, and go to FETCH.
REQ-015 In FETCH, SHALL issue a synchronous read of the delay line at wr_ptr (the oldest entry) and go to CALC.
REQ-016 In CALC, SHALL register writedata_* from the captured mode: pass = in; mute = 0; delay-only = delayed; echo = sat(in + (delayed >>> ECHO_SHIFT)); then go to PUSH.
REQ-017 Echo sum SHALL be computed at DATA_W+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 In PUSH, SHALL hold writedata_* stable and write=0 until write_ready=1, then assert write for exactly one cycle.
REQ-019 In that same cycle, SHALL write the captured input into the delay line at wr_ptr, increment wr_ptr modulo DEPTH (DEPTH-1 wraps to 0), and return to IDLE.
REQ-020 Minimum latency SHALL be 3 cycles from the read strobe to the write strobe.
REQ-021 read and write SHALL never be asserted in the same cycle.
REQ-022 No new sample SHALL be read before the previous one has been pushed; read_ready held high in FETCH, CALC or PUSH SHALL be ignored.
REQ-023 A saturating fill counter SHALL count writes up to DEPTH; while it is below DEPTH, the delayed sample SHALL be treated as 0 regardless of RAM contents.
REQ-024 A mode change after capture SHALL NOT affect the sample in flight.
REQ-025 The delay line SHALL be updated with the raw input in every mode, including mute and pass.

Reset
REQ-026 While reset=1, SHALL force state=IDLE, read=0, write=0, writedata_*=0, wr_ptr=0 and fill counter=0.
REQ-027 Reset during FETCH, CALC or PUSH SHALL abort the sample with no write strobe and no delay-line write.
REQ-028 RAM contents SHALL NOT need clearing, because REQ-023 masks them.
REQ-029 The first read strobe after reset SHALL occur no earlier than the first cycle after reset deasserts.

Structure
REQ-030 A shared package audio_pkg SHALL hold the mode encoding constants and the FSM state enumeration.
REQ-031 The delay line SHALL be sub-module audio_delay_ram, a simple dual-port RAM that is 2*DATA_W wide and DEPTH deep, with 1-cycle registered read and inferrable block RAM.
REQ-032 Top-level codec, clock-generator and I2C config wiring SHALL remain outside this block.

Verification (DATA_W=24, DEPTH=4, ECHO_SHIFT=1)
REQ-033 Pass: mode=00, feed L=0x000123, R=0xFFFF00 with write_ready=1 -> write 3 cycles after read, writedata matches input exactly.
REQ-034 Delay/wrap: mode=10, feed samples 1..10 -> first 4 outputs are 0, then outputs are 1..6, proving pointer wrap at 3->0.
REQ-035 Echo saturation: mode=11, prefill 4 samples of 0x7FFFFF, then input 0x7FFFFF -> output 0x7FFFFF; prefill 0x800000, then input 0x800000 -> output 0x800000.
REQ-036 Backpressure: hold write_ready=0 for 20 cycles in PUSH while read_ready=1 -> writedata stable, no read strobe, one write strobe when write_ready rises.
REQ-037 Reset mid-PUSH: assert reset with write_ready=0 -> no write strobe; the next 4 outputs in mode=10 are 0.
REQ-038 Mute: mode=01 for 4 samples, then mode=10 -> outputs are 0 while muted, then the muted inputs appear delayed.
